// File: rtl/inst_fetch.sv
// inst_fetch: program counter and byte-serial instruction fetch for the IF stage.
// Each 32-bit instruction is read as four little-endian byte accesses over an
// 8-bit memory port. Downstream stalls hold the presented instruction. Branch
// redirects abort the fetch in progress.
// Optional feature: define ICACHE_EN to build a 32-entry direct-mapped
// instruction cache. It is indexed by pc[6:2] and tagged with pc[31:7].
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_enable_o
);

    // The low two bits of FETCH0..FETCH3 are the byte index k.
    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        READY  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // PC of the instruction being fetched
    logic [23:0] buf_q, buf_d;        // bytes 0..2 collected so far
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        en_q, en_d;

    logic [1:0]  byte_idx;
    logic        in_fetch;
    logic        ack_ok;
    logic        cache_hit;
    logic [31:0] cache_word;

    assign byte_idx = state_q[1:0];
    assign in_fetch = (state_q != READY);

    // A cache hit in FETCH0 suppresses the memory request.
    // During reset the request is forced low.
    assign mem_req_o  = !rst && in_fetch && !cache_hit;
    assign mem_addr_o = rst ? 32'h0 : (pc_q + {30'b0, byte_idx});

    // An ack counts only when a request is actually outstanding.
    assign ack_ok = mem_ack_i && mem_req_o;

    assign pc_o          = pc_out_q;
    assign inst_o        = inst_q;
    assign inst_enable_o = en_q;

`ifdef ICACHE_EN
    logic [31:0] data_mem [32];
    logic [24:0] tag_mem  [32];
    logic [31:0] valid_q, valid_d;
    logic [4:0]  cache_idx;
    logic        cache_wr;

    assign cache_idx  = pc_q[6:2];
    assign cache_hit  = (state_q == FETCH0) && valid_q[cache_idx] &&
                        (tag_mem[cache_idx] == pc_q[31:7]) && (pc_q[1:0] == 2'b00);
    assign cache_word = data_mem[cache_idx];
    // Fill on the last byte of an aligned miss, unless a redirect kills it.
    assign cache_wr   = (state_q == FETCH3) && ack_ok && !branch_flag_i &&
                        (pc_q[1:0] == 2'b00);

    // Set the valid bit of the entry being filled.
    always_comb begin
        valid_d = valid_q;
        if (cache_wr) begin
            valid_d[cache_idx] = 1'b1;
        end
    end

    // Valid bits are the only cache state that needs clearing on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag storage is written on fills and is never reset.
    always_ff @(posedge clk) begin
        if (cache_wr) begin
            data_mem[cache_idx] <= {mem_data_i, buf_q};
            tag_mem[cache_idx]  <= pc_q[31:7];
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = 32'h0;
`endif

    // Next-state logic: a redirect overrides everything, including a same-cycle ack.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        en_d     = en_q;
        if (branch_flag_i) begin
            pc_d    = branch_target_i;
            buf_d   = 24'h0;
            en_d    = 1'b0;
            state_d = FETCH0;
        end else begin
            case (state_q)
                FETCH0: begin
                    if (cache_hit) begin
                        inst_d   = cache_word;
                        pc_out_d = pc_q;
                        en_d     = 1'b1;
                        state_d  = READY;
                    end else if (ack_ok) begin
                        buf_d[7:0] = mem_data_i;
                        state_d    = FETCH1;
                    end
                end
                FETCH1: begin
                    if (ack_ok) begin
                        buf_d[15:8] = mem_data_i;
                        state_d     = FETCH2;
                    end
                end
                FETCH2: begin
                    if (ack_ok) begin
                        buf_d[23:16] = mem_data_i;
                        state_d      = FETCH3;
                    end
                end
                FETCH3: begin
                    if (ack_ok) begin
                        inst_d   = {mem_data_i, buf_q};
                        pc_out_d = pc_q;
                        en_d     = 1'b1;
                        buf_d    = 24'h0;
                        state_d  = READY;
                    end
                end
                READY: begin
                    if (!stall_i) begin
                        pc_d    = pc_q + 32'd4;
                        en_d    = 1'b0;
                        state_d = FETCH0;
                    end
                end
                default: begin
                    buf_d   = 24'h0;
                    en_d    = 1'b0;
                    state_d = FETCH0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any partial fetch at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH0;
            pc_q     <= RESET_PC;
            buf_q    <= 24'h0;
            inst_q   <= 32'h0;
            pc_out_q <= 32'h0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch.
// A zero-wait byte memory answers requests in the same cycle.
// Acks can be withheld or forced for individual tests.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_enable_o;

    logic ack_en;
    logic ack_force;
    int   n_checks;
    int   n_fail;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_enable_o   (inst_enable_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents, by aligned word address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: word_at = 32'h0050_0093;
            32'h0000_0004: word_at = 32'h00A0_0113;
            32'h0000_0008: word_at = 32'h1122_3344;
            32'h0000_0080: word_at = 32'h1234_5678;
            32'h0000_0100: word_at = 32'hDEAD_BEEF;
            32'h0000_0104: word_at = 32'hCAFE_F00D;
            default:       word_at = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        case (a[1:0])
            2'd0:    byte_at = w[7:0];
            2'd1:    byte_at = w[15:8];
            2'd2:    byte_at = w[23:16];
            default: byte_at = w[31:24];
        endcase
    endfunction

    // Zero-wait memory responder.
    always_comb begin
        mem_ack_i  = (mem_req_o && ack_en) || ack_force;
        mem_data_i = byte_at(mem_addr_o);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Expects FETCH0 at base to have just been entered.
    // Then expects four byte requests followed by the presented word.
    task automatic run_fetch(input logic [31:0] base, input logic [31:0] exp);
        for (int k = 0; k < 4; k++) begin
            check_eq("fetch_addr", mem_addr_o, base + 32'(k));
            check_eq("fetch_req", {31'b0, mem_req_o}, 32'd1);
            check_eq("fetch_en_low", {31'b0, inst_enable_o}, 32'd0);
            step();
        end
        check_eq("inst_en", {31'b0, inst_enable_o}, 32'd1);
        check_eq("inst", inst_o, exp);
        check_eq("inst_pc", pc_o, base);
        $display("inst presented: pc=%h inst=%h", pc_o, inst_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        ack_en          = 1'b1;
        ack_force       = 1'b0;

        // Reset values.
        step();
        step();
        check_eq("rst_en", {31'b0, inst_enable_o}, 32'd0);
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_addr", mem_addr_o, 32'h0);
        check_eq("rst_req", {31'b0, mem_req_o}, 32'd0);
        rst = 1'b0;
        #1;

        // First fetch from RESET_PC.
        run_fetch(32'h0, 32'h0050_0093);

        // Stall in READY for three cycles. Stray acks must be ignored.
        stall_i   = 1'b1;
        ack_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_en", {31'b0, inst_enable_o}, 32'd1);
            check_eq("stall_inst", inst_o, 32'h0050_0093);
            check_eq("stall_pc", pc_o, 32'h0);
            check_eq("stall_req", {31'b0, mem_req_o}, 32'd0);
        end
        stall_i   = 1'b0;
        ack_force = 1'b0;
        step();
        check_eq("post_stall_addr", mem_addr_o, 32'h4);
        check_eq("post_stall_req", {31'b0, mem_req_o}, 32'd1);
        check_eq("post_stall_en", {31'b0, inst_enable_o}, 32'd0);

        // Withhold the ack on byte 2 for two cycles.
        step();
        check_eq("wh_addr1", mem_addr_o, 32'h5);
        step();
        check_eq("wh_addr2", mem_addr_o, 32'h6);
        ack_en = 1'b0;
        step();
        check_eq("wh_hold1", mem_addr_o, 32'h6);
        check_eq("wh_req1", {31'b0, mem_req_o}, 32'd1);
        step();
        check_eq("wh_hold2", mem_addr_o, 32'h6);
        check_eq("wh_en_low", {31'b0, inst_enable_o}, 32'd0);
        ack_en = 1'b1;
        step();
        check_eq("wh_addr3", mem_addr_o, 32'h7);
        check_eq("wh_en_low2", {31'b0, inst_enable_o}, 32'd0);
        step();
        check_eq("wh_en", {31'b0, inst_enable_o}, 32'd1);
        check_eq("wh_inst", inst_o, 32'h00A0_0113);
        check_eq("wh_pc", pc_o, 32'h4);
        $display("inst presented: pc=%h inst=%h", pc_o, inst_o);

        // Branch to 0x100 while in FETCH2, with an ack in the same cycle.
        step();
        check_eq("br_addr0", mem_addr_o, 32'h8);
        step();
        check_eq("br_addr1", mem_addr_o, 32'h9);
        step();
        check_eq("br_addr2", mem_addr_o, 32'hA);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        run_fetch(32'h100, 32'hDEAD_BEEF);

        // Reset pulsed in the middle of FETCH1.
        step();
        check_eq("mid_addr0", mem_addr_o, 32'h104);
        step();
        check_eq("mid_addr1", mem_addr_o, 32'h105);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_en", {31'b0, inst_enable_o}, 32'd0);
        check_eq("mid_rst_inst", inst_o, 32'h0);
        check_eq("mid_rst_pc", pc_o, 32'h0);
        check_eq("mid_rst_addr", mem_addr_o, 32'h0);
        check_eq("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        run_fetch(32'h0, 32'h0050_0093);

        // Loop: execute 0x4, then branch back to 0x0.
        // The branch is raised together with a stall.
        step();
        run_fetch(32'h4, 32'h00A0_0113);
        stall_i         = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0;
        step();
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        check_eq("loop_en_low", {31'b0, inst_enable_o}, 32'd0);
`ifdef ICACHE_EN
        check_eq("hit_req", {31'b0, mem_req_o}, 32'd0);
        step();
        check_eq("hit_en", {31'b0, inst_enable_o}, 32'd1);
        check_eq("hit_inst", inst_o, 32'h0050_0093);
        check_eq("hit_pc", pc_o, 32'h0);
        $display("inst presented: pc=%h inst=%h", pc_o, inst_o);
`else
        run_fetch(32'h0, 32'h0050_0093);
`endif

        // 0x80 aliases index 0: it misses, and its refill evicts 0x0.
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h80;
        step();
        branch_flag_i = 1'b0;
        run_fetch(32'h80, 32'h1234_5678);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0;
        step();
        branch_flag_i = 1'b0;
        run_fetch(32'h0, 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
